// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Arbitrates the unified memory port between instruction fetch (requester 0)
// and data load/store (requester 1). Grants are decoded from a registered
// FSM state, so a request becomes a grant one clock after it is sampled and
// no combinational path exists from req to gnt.
//
// Contention: an owner may keep the port for at most MAX_HOLD consecutive
// cycles while the other requester is waiting. After that, the port is
// handed over. Without a contender, the owner keeps the port indefinitely.
// MAX_HOLD must lie in 1..15 because hold_cnt is a 4-bit counter.
//
// Build option (macro ARB_ROUND_ROBIN_EN):
//   defined   - IDLE ties go to the requester that did not own the port last.
//   undefined - IDLE ties go to the data requester (fixed priority).
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_HOLD   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic                  we1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  stall0,
  output logic                  stall1,
  output logic                  sel,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata
);

  // FSM encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  // Last count value before the owner must give the port away
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic [3:0] hold_cnt_q;
  logic [3:0] hold_cnt_d;
  logic [1:0] tie_state_s;
  logic       contender_s;
  logic       hold_expired_s;

`ifdef ARB_ROUND_ROBIN_EN
  // 0 = fetch owned the port most recently, 1 = data did
  logic last_owner_q;
  logic last_owner_d;

  // IDLE tie-break: hand the port to whoever did not have it last
  always_comb begin
    if (last_owner_q) begin
      tie_state_s = GNT0;
    end else begin
      tie_state_s = GNT1;
    end
  end

  // Remember the owner on every entry into a grant state
  always_comb begin
    last_owner_d = last_owner_q;
    if ((state_d == GNT0) && (state_q != GNT0)) begin
      last_owner_d = 1'b0;
    end else if ((state_d == GNT1) && (state_q != GNT1)) begin
      last_owner_d = 1'b1;
    end else begin
      last_owner_d = last_owner_q;
    end
  end

  // Last-owner register; cleared by reset so the first tie goes to data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner_q <= 1'b0;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`else
  // IDLE tie-break: fixed data priority
  always_comb begin
    tie_state_s = GNT1;
  end
`endif

  // Is the other requester waiting while someone owns the port?
  always_comb begin
    contender_s = 1'b0;
    case (state_q)
      GNT0:    contender_s = req1;
      GNT1:    contender_s = req0;
      IDLE:    contender_s = 1'b0;
      default: contender_s = 1'b0;
    endcase
  end

  // Owner has used up its share of the port under contention
  always_comb begin
    hold_expired_s = contender_s && (hold_cnt_q == HOLD_LAST);
  end

  // Next-state logic: handoff without bubble, forced release on hold expiry
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          state_d = tie_state_s;
        end else if (req1) begin
          state_d = GNT1;
        end else if (req0) begin
          state_d = GNT0;
        end else begin
          state_d = IDLE;
        end
      end
      GNT0: begin
        if (!req0) begin
          if (req1) begin
            state_d = GNT1;
          end else begin
            state_d = IDLE;
          end
        end else if (hold_expired_s) begin
          state_d = GNT1;
        end else begin
          state_d = GNT0;
        end
      end
      GNT1: begin
        if (!req1) begin
          if (req0) begin
            state_d = GNT0;
          end else begin
            state_d = IDLE;
          end
        end else if (hold_expired_s) begin
          state_d = GNT0;
        end else begin
          state_d = GNT1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Hold counter: restarts on each ownership change, counts only under
  // contention and saturates so it can never wrap past the limit
  always_comb begin
    hold_cnt_d = 4'd0;
    if (state_d != state_q) begin
      hold_cnt_d = 4'd0;
    end else if (contender_s) begin
      if (hold_cnt_q == HOLD_LAST) begin
        hold_cnt_d = hold_cnt_q;
      end else begin
        hold_cnt_d = hold_cnt_q + 4'd1;
      end
    end else begin
      hold_cnt_d = 4'd0;
    end
  end

  // State and hold counter registers; reset acts immediately, even mid-transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Output decode from the registered state; writes only while data owns the port
  always_comb begin
    gnt0      = (state_q == GNT0);
    gnt1      = (state_q == GNT1);
    sel       = gnt1;
    stall0    = req0 & ~gnt0;
    stall1    = req1 & ~gnt1;
    mem_we    = gnt1 & req1 & we1;
    mem_wdata = wdata1;
    if (sel) begin
      mem_addr = addr1;
    end else begin
      mem_addr = addr0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Scenario tasks push expected port snapshots into a queue as stimulus is
// applied and pop them when the DUT output is sampled, #1 after the edge.
// A second instance with MAX_HOLD=1 shares the inputs to cover the
// alternate-every-cycle contention case.
// Tie-break expectation follows ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_port_arbiter;

  logic       clk;
  logic       rst;
  logic       req0;
  logic [7:0] addr0;
  logic       req1;
  logic [7:0] addr1;
  logic       we1;
  logic [7:0] wdata1;

  logic       gnt0, gnt1, stall0, stall1, sel, mem_we;
  logic [7:0] mem_addr, mem_wdata;

  logic       h1_gnt0, h1_gnt1, h1_stall0, h1_stall1, h1_sel, h1_mem_we;
  logic [7:0] h1_mem_addr, h1_mem_wdata;

  int unsigned checks;
  int unsigned errors;

  // snapshot layout: {gnt0, gnt1, sel, stall0, stall1, mem_we, mem_addr, mem_wdata}
  logic [21:0] exp_q[$];
  logic [21:0] exp1_q[$];

  mem_port_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0),
    .req1(req1), .addr1(addr1), .we1(we1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .stall0(stall0), .stall1(stall1),
    .sel(sel), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata)
  );

  mem_port_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_HOLD(1)) dut_h1 (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0),
    .req1(req1), .addr1(addr1), .we1(we1), .wdata1(wdata1),
    .gnt0(h1_gnt0), .gnt1(h1_gnt1), .stall0(h1_stall0), .stall1(h1_stall1),
    .sel(h1_sel), .mem_addr(h1_mem_addr), .mem_we(h1_mem_we), .mem_wdata(h1_mem_wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [21:0] mk(input logic g0, input logic g1, input logic s0,
                                     input logic s1, input logic we, input logic [7:0] a,
                                     input logic [7:0] wd);
    return {g0, g1, g1, s0, s1, we, a, wd};
  endfunction

  function automatic logic [21:0] obs();
    return {gnt0, gnt1, sel, stall0, stall1, mem_we, mem_addr, mem_wdata};
  endfunction

  function automatic logic [21:0] obs_h1();
    return {h1_gnt0, h1_gnt1, h1_sel, h1_stall0, h1_stall1, h1_mem_we, h1_mem_addr, h1_mem_wdata};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [21:0] e;
    logic [21:0] o;
    rst = 1'b1; req0 = 1'b1; addr0 = 8'h11; req1 = 1'b0; addr1 = 8'h00; we1 = 1'b0; wdata1 = 8'h00;
    repeat (2) tick();
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 8'h00));
    e = exp_q.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL reset_hold got=%h exp=%h", o, e); end
    // bring up a write grant, then reset in the middle of it
    rst = 1'b0; req0 = 1'b0; req1 = 1'b1; we1 = 1'b1; addr1 = 8'h80; wdata1 = 8'h5A;
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h80, 8'h5A));
    tick();
    e = exp_q.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL reset_pre_gnt1 got=%h exp=%h", o, e); end
    #2 rst = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 8'h5A));
    #1;
    e = exp_q.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL reset_async got=%h exp=%h", o, e); end
    tick();
    rst = 1'b0; req1 = 1'b0; we1 = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 8'h5A));
    tick();
    e = exp_q.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL reset_release_idle got=%h exp=%h", o, e); end
  endtask

  task automatic test_fetch_only();
    logic [21:0] e;
    logic [21:0] o;
    req0 = 1'b1; addr0 = 8'h3C;
    for (int i = 0; i < 21; i++) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h5A));
    for (int i = 0; i < 21; i++) begin
      tick();
      e = exp_q.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL fetch_hold[%0d] got=%h exp=%h", i, o, e); end
      checks++;
      if (dut.hold_cnt_q !== 4'd0) begin
        errors++; $display("FAIL fetch_hold_cnt[%0d] got=%0d exp=0", i, dut.hold_cnt_q);
      end
    end
    req0 = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h5A));
    tick();
    e = exp_q.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL fetch_release got=%h exp=%h", o, e); end
  endtask

  task automatic test_write();
    logic [21:0] e;
    logic [21:0] o;
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h80; wdata1 = 8'hA5;
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h80, 8'hA5));
    tick();
    e = exp_q.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL write_grant got=%h exp=%h", o, e); end
    req1 = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 8'hA5));
    tick();
    e = exp_q.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL write_drop got=%h exp=%h", o, e); end
    we1 = 1'b0;
  endtask

  task automatic test_contention();
    logic [21:0] e;
    logic [21:0] o;
    logic        g1;
    logic        h1;
    addr0 = 8'h10; addr1 = 8'h20; wdata1 = 8'h00; we1 = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      g1 = (((k - 1) / 4) % 2) == 0;
      h1 = (k % 2) == 1;
      exp_q.push_back(mk(~g1, g1, g1, ~g1, 1'b0, g1 ? 8'h20 : 8'h10, 8'h00));
      exp1_q.push_back(mk(~h1, h1, h1, ~h1, 1'b0, h1 ? 8'h20 : 8'h10, 8'h00));
    end
    for (int k = 1; k <= 16; k++) begin
      tick();
      e = exp_q.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL contention_hold4[%0d] got=%h exp=%h", k, o, e); end
      e = exp1_q.pop_front(); o = obs_h1(); checks++;
      if (o !== e) begin errors++; $display("FAIL contention_hold1[%0d] got=%h exp=%h", k, o, e); end
    end
    req0 = 1'b0; req1 = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00));
    tick();
    e = exp_q.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL contention_idle got=%h exp=%h", o, e); end
  endtask

  task automatic test_handoff();
    logic [21:0] e;
    logic [21:0] o;
    req0 = 1'b1; addr0 = 8'h44;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h44, 8'h00));
    tick();
    e = exp_q.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL handoff_gnt0 got=%h exp=%h", o, e); end
    req0 = 1'b0; req1 = 1'b1; addr1 = 8'h55;
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55, 8'h00));
    tick();
    e = exp_q.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL handoff_gnt1 got=%h exp=%h", o, e); end
    req1 = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h44, 8'h00));
    tick();
    e = exp_q.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL handoff_idle got=%h exp=%h", o, e); end
  endtask

  task automatic test_tie_break();
    logic [21:0] e;
    logic [21:0] o;
    // last grant was to data and ended in IDLE
    addr0 = 8'h66; addr1 = 8'h77;
    req0 = 1'b1; req1 = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h66, 8'h00));
`else
    exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h77, 8'h00));
`endif
    tick();
    e = exp_q.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL tie_break got=%h exp=%h", o, e); end
    req0 = 1'b0; req1 = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h66, 8'h00));
    tick();
    e = exp_q.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL tie_idle got=%h exp=%h", o, e); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fetch_only();
    test_write();
    test_contention();
    test_handoff();
    test_tie_break();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates the single unified memory port between requester 0 (instruction fetch) and requester 1 (data load/store). It drives the select of the 2:1 address/data mux in front of memory and issues registered grants. Requesters that are not granted are told to stall. The block sits between the fetch unit, the load/store unit and the memory wrapper.

Parameters:
- ADDR_WIDTH, 8, width of the memory address.
- DATA_WIDTH, 8, width of the write data.
- MAX_HOLD, 4, maximum number of consecutive cycles one requester may keep a grant while the other is requesting. Legal values 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0  in  1  fetch request.
- addr0  in  ADDR_WIDTH  fetch address.
- req1  in  1  data request.
- addr1  in  ADDR_WIDTH  data address.
- we1  in  1  data write enable; meaningful only while req1=1.
- wdata1  in  DATA_WIDTH  data write value.
- gnt0  out  1  fetch owns the port this cycle.
- gnt1  out  1  data owns the port this cycle.
- stall0  out  1  req0 & ~gnt0.
- stall1  out  1  req1 & ~gnt1.
- sel  out  1  mux select: 0 = requester 0 path, 1 = requester 1 path.
- mem_addr  out  ADDR_WIDTH  muxed address.
- mem_we  out  1  memory write strobe.
- mem_wdata  out  DATA_WIDTH  wdata1 passthrough.

Behaviour:
- FSM states: IDLE, GNT0, GNT1. State is registered.
- hold_cnt is a 4-bit register.
- Reset (asynchronous, takes effect immediately, also mid-transfer): state=IDLE, hold_cnt=0, gnt0=gnt1=0, sel=0, mem_we=0, stall outputs follow req.
- Grant latency: a request sampled at edge N in IDLE gives a grant visible after edge N (one cycle from req to gnt). No combinational path from req to gnt.
- Outputs are decoded from state:
  - gnt0=(state==GNT0); gnt1=(state==GNT1); sel=gnt1.
  - mem_addr = sel ? addr1 : addr0.
  - mem_wdata = wdata1.
  - mem_we = gnt1 & req1 & we1. No write ever occurs in IDLE or GNT0.
- IDLE transitions: req1 -> GNT1 (data priority); else req0 -> GNT0; else stay in IDLE.
- GNTx transitions (x = owner, y = other requester):
  - reqx=0 and reqy=1 -> GNTy (direct handoff, no idle bubble).
  - reqx=0 and reqy=0 -> IDLE.
  - reqx=1, reqy=1 and hold_cnt==MAX_HOLD-1 -> GNTy (forced release).
  - otherwise stay in GNTx.
- hold_cnt rules:
  - Cleared on every state change.
  - In GNTx, increments while reqy=1, saturating at MAX_HOLD-1.
  - Held at 0 while reqy=0, so an owner with no contender keeps the port indefinitely.
- With MAX_HOLD=1, contention alternates every cycle.
- Simultaneous req0 and req1 in IDLE: GNT1 wins (default build).
- A requester whose grant is revoked by forced release sees stall asserted in the next cycle. It must hold its req and address stable until re-granted.

Optional Feature:
ARB_ROUND_ROBIN_EN:
- Defined: adds a last_owner register (reset 0), updated on every entry into GNT0/GNT1. In IDLE with both requests high, the grant goes to the requester that is not last_owner. Single-request behaviour is unchanged.
- Undefined: fixed data priority in IDLE as described above; no last_owner register.

Test Plan:
- Reset: rst=1 mid-GNT1 with we1=1 -> immediately state=IDLE, gnt0=gnt1=0, mem_we=0, sel=0.
- Fetch only: req0=1, addr0=0x3C from IDLE -> gnt0=1 after the first edge, mem_addr=0x3C, sel=0, stall0=0. It then holds for 20 cycles with hold_cnt=0.
- Write: req1=1, we1=1, addr1=0x80, wdata1=0xA5 from IDLE -> next cycle gnt1=1, sel=1, mem_addr=0x80, mem_we=1, mem_wdata=0xA5. Dropping req1 -> next cycle mem_we=0 and state IDLE.
- Contention, MAX_HOLD=4: req0 and req1 held high from IDLE -> gnt1 for 4 cycles, then gnt0 for 4 cycles, alternating. stall0/stall1 are the exact complement of the grants.
- Handoff: in GNT0, req0 falls while req1=1 in the same cycle -> gnt1=1 next cycle, no IDLE cycle.
- ARB_ROUND_ROBIN_EN defined: after a GNT1 ends in IDLE, simultaneous req0 and req1 -> GNT0. The same stimulus with the macro undefined -> GNT1.
